// File: rtl/shift_unit_seq_if.sv
// shift_unit_seq_if: S-bus operand/start request and result/flag return for shift_unit_seq.
interface shift_unit_seq_if #(
   parameter int DATA_W = 16,
   parameter int SH_W   = 4
);
   logic              start;
   logic [1:0]        op;
   logic [SH_W-1:0]   amount;
   logic [DATA_W-1:0] operand;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] result;
   logic              flag_s;
   logic              flag_z;
   logic              flag_c;
   logic              flag_v;
   modport master (
      output start, op, amount, operand,
      input  busy, done, result, flag_s, flag_z, flag_c, flag_v
   );
   modport slave (
      input  start, op, amount, operand,
      output busy, done, result, flag_s, flag_z, flag_c, flag_v
   );
endinterface

// File: rtl/shift_unit_seq.sv
// shift_unit_seq: multi-cycle S-bus shifter (SLL/SLR/SRL/SRA) with start/busy/done and S/Z/C/V flags.
// Define SHIFT_UNIT_BARREL_EN to apply the whole remaining shift in one cycle.
module shift_unit_seq #(
   parameter int DATA_W = 16,
   parameter int SH_W   = 4
) (
   input logic             clk,
   input logic             rst_n,
   shift_unit_seq_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t            state_q, state_d;
   logic [DATA_W-1:0] work_q, work_d, res_q, res_d, step_w;
   logic [SH_W-1:0]   cnt_q, cnt_d, cnt_step;
   logic [1:0]        op_q, op_d;
   logic              carry_q, carry_d, step_c;
   logic              s_q, s_d, z_q, z_d, c_q, c_d;
   logic              accept, shifting, finish;
   assign accept   = bus.start && state_q != SHIFT;
   assign shifting = state_q == SHIFT && cnt_q != '0;
   assign finish   = state_q == SHIFT && cnt_q == '0;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   always_comb
      state_d = (state_q == SHIFT) ? ((cnt_q == '0) ? DONE : SHIFT) : (bus.start ? SHIFT : IDLE);
   always_comb begin
      bus.busy   = state_q == SHIFT;
      bus.done   = state_q == DONE;
      bus.result = res_q;
      bus.flag_s = s_q;
      bus.flag_z = z_q;
      bus.flag_c = c_q;
      bus.flag_v = 1'b0;
   end
`ifdef SHIFT_UNIT_BARREL_EN
   logic [SH_W-1:0]          neg_cnt;
   logic signed [DATA_W-1:0] sra_w;
   assign neg_cnt = -cnt_q;
   assign sra_w   = $signed(work_q) >>> cnt_q;
   // Last bit out: left ops lose bit DATA_W-n, right ops lose bit n-1
   always_comb begin
      step_w   = op_q == 2'b00 ? work_q << cnt_q :
                 op_q == 2'b01 ? (work_q << cnt_q) | (work_q >> neg_cnt) :
                 op_q == 2'b10 ? work_q >> cnt_q : sra_w;
      step_c   = op_q[1] ? work_q[cnt_q - SH_W'(1)] : work_q[neg_cnt];
      cnt_step = '0;
   end
`else
   // op[0] selects the fill: 0 for logical shifts, MSB for rotate-left and arithmetic right
   always_comb begin
      step_w   = op_q[1] ? {op_q[0] & work_q[DATA_W-1], work_q[DATA_W-1:1]}
                         : {work_q[DATA_W-2:0], op_q[0] & work_q[DATA_W-1]};
      step_c   = op_q[1] ? work_q[0] : work_q[DATA_W-1];
      cnt_step = cnt_q - SH_W'(1);
   end
`endif
   always_comb begin
      work_d  = accept ? bus.operand : shifting ? step_w : work_q;
      carry_d = accept ? 1'b0 : shifting ? step_c : carry_q;
      cnt_d   = accept ? bus.amount : shifting ? cnt_step : cnt_q;
      op_d    = accept ? bus.op : op_q;
      res_d   = finish ? work_q : res_q;
      s_d     = finish ? work_q[DATA_W-1] : s_q;
      z_d     = finish ? work_q == '0 : z_q;
      c_d     = finish ? carry_q : c_q;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         work_q  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         op_q    <= '0;
         res_q   <= '0;
         s_q     <= 1'b0;
         z_q     <= 1'b0;
         c_q     <= 1'b0;
      end else begin
         work_q  <= work_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         res_q   <= res_d;
         s_q     <= s_d;
         z_q     <= z_d;
         c_q     <= c_d;
      end
endmodule

// File: tb/tb_shift_unit_seq.sv
// tb_shift_unit_seq: directed vectors into a scoreboard queue; a negedge monitor checks each done.
module tb_shift_unit_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;
   int   bsy = 0;
   shift_unit_seq_if bus();
   shift_unit_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   typedef struct {
      logic [15:0] res;
      logic        c;
      int          cyc;
      int          lat;
   } exp_t;
   exp_t q[$];
   exp_t e;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask
   function automatic int lat(input logic [3:0] amt);
`ifdef SHIFT_UNIT_BARREL_EN
      return amt == 4'd0 ? 1 : 2;
`else
      return int'(amt) + 1;
`endif
   endfunction
   always @(negedge clk)
      if (!rst_n) bsy = 0;
      else begin
         if (bus.busy) bsy++;
         if (bus.done) begin
            if (q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL spurious_done: done at cycle %0d, expected none", cyc);
            end else begin
               e = q.pop_front();
               chk("result", bus.result, e.res);
               chk("flag_s", bus.flag_s, e.res[15]);
               chk("flag_z", bus.flag_z, e.res == 16'h0);
               chk("flag_c", bus.flag_c, e.c);
               chk("flag_v", bus.flag_v, 0);
               chk("done_cycle", cyc, e.cyc);
               chk("busy_cycles", bsy, e.lat);
            end
            bsy = 0;
         end
      end
   task automatic wait_idle();
      for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
      if (q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL done_timeout: %0d results outstanding, expected 0", q.size());
         q.delete();
      end
   endtask
   task automatic issue(input logic [1:0] op, input logic [3:0] amt, input logic [15:0] opnd,
                        input logic [15:0] res, input logic c);
      bus.start = 1'b1;
      bus.op = op;
      bus.amount = amt;
      bus.operand = opnd;
      q.push_back('{res, c, cyc + 1 + lat(amt), lat(amt)});
   endtask
   task automatic run(input logic [1:0] op, input logic [3:0] amt, input logic [15:0] opnd,
                      input logic [15:0] res, input logic c);
      @(negedge clk);
      issue(op, amt, opnd, res, c);
      @(negedge clk);
      bus.start = 1'b0;
      bus.operand = ~opnd;
      bus.amount = ~amt;
      wait_idle();
   endtask
   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int t0;
      bus.start = 1'b0;
      bus.op = 2'b00;
      bus.amount = 4'd0;
      bus.operand = 16'h0;
      repeat (3) @(negedge clk);
      chk("reset_busy", bus.busy, 0);
      chk("reset_done", bus.done, 0);
      chk("reset_result", bus.result, 0);
      rst_n = 1'b1;
      run(2'b00, 4'd1, 16'h8001, 16'h0002, 1'b1);
      run(2'b11, 4'd15, 16'h8000, 16'hFFFF, 1'b0);
      run(2'b10, 4'd1, 16'h0001, 16'h0000, 1'b1);
      run(2'b01, 4'd4, 16'h8001, 16'h0018, 1'b0);
      run(2'b11, 4'd3, 16'h8F0F, 16'hF1E1, 1'b1);
      // amount 0 with start held through DONE: second op accepted with no IDLE cycle
      @(negedge clk);
      t0 = cyc + 1;
      issue(2'b00, 4'd0, 16'h1234, 16'h1234, 1'b0);
      @(negedge clk);
      bus.op = 2'b10;
      bus.amount = 4'd2;
      bus.operand = 16'h00F2;
      q.push_back('{16'h003C, 1'b1, t0 + 2 + lat(4'd2), lat(4'd2)});
      @(negedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      wait_idle();
      // start pulsed mid-SHIFT with new inputs is ignored
      @(negedge clk);
      issue(2'b00, 4'd8, 16'h01AB, 16'hAB00, 1'b1);
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.op = 2'b11;
      bus.amount = 4'd3;
      bus.operand = 16'hFFFF;
      @(negedge clk);
      bus.start = 1'b0;
      wait_idle();
      // reset during SHIFT aborts with no done
      @(negedge clk);
      bus.start = 1'b1;
      bus.op = 2'b00;
      bus.amount = 4'd10;
      bus.operand = 16'h0043;
      @(negedge clk);
      bus.start = 1'b0;
      repeat ((lat(4'd10) > 5 ? 5 : 1) - 1) @(negedge clk);
      chk("pre_abort_busy", bus.busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", bus.busy, 0);
      chk("abort_done", bus.done, 0);
      chk("abort_result", bus.result, 0);
      chk("abort_flags", {bus.flag_s, bus.flag_z, bus.flag_c, bus.flag_v}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (15) @(negedge clk);
      run(2'b00, 4'd10, 16'h0043, 16'h0C00, 1'b1);
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
